// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage: valid/ready request channel
// plus a valid-only, in-order response channel.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns PCF, keeps at most one imem read in flight and fills the
// IF/ID register, with a one-entry skid for responses that land while decode stalls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PCSrcE,
    input  logic [31:0]   PCTargetE,
    input  logic          StallD,
    fetch_unit_if.master  imem,
    output logic [31:0]   InstrD,
    output logic [31:0]   PCD,
    output logic [31:0]   PCPlus4D,
    output logic          ValidD,
    output logic [31:0]   PCF
);

    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_HOLD} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pcf, w_pcf_next;
    logic        r_req_valid;
    logic        r_drop, w_drop_next;
    logic        r_skid_valid, w_skid_valid_next;
    logic [31:0] r_skid_instr, w_skid_instr_next;
    logic [31:0] r_skid_pc, w_skid_pc_next;
    logic        r_valid_d, w_valid_d_next;
    logic [31:0] r_instr_d, w_instr_d_next;
    logic [31:0] r_pc_d, w_pc_d_next;
    logic [31:0] r_pc_plus4_d, w_pc_plus4_d_next;

    logic        w_accept;
    logic        w_d_free;
    logic [31:0] w_pcf_plus4;

    assign w_accept    = (r_state == ST_ISSUE) && r_req_valid && imem.imem_req_ready;
    assign w_d_free    = !r_valid_d || !StallD;
    assign w_pcf_plus4 = r_pcf + 32'd4;

    always_comb begin
        w_state_next      = r_state;
        w_pcf_next        = r_pcf;
        w_drop_next       = r_drop;
        w_skid_valid_next = r_skid_valid;
        w_skid_instr_next = r_skid_instr;
        w_skid_pc_next    = r_skid_pc;
        w_valid_d_next    = r_valid_d;
        w_instr_d_next    = r_instr_d;
        w_pc_d_next       = r_pc_d;
        w_pc_plus4_d_next = r_pc_plus4_d;

        if (PCSrcE) begin
            // Redirect flushes D and skid; an in-flight read is tracked by drop.
            w_pcf_next        = {PCTargetE[31:2], 2'b00};
            w_valid_d_next    = 1'b0;
            w_instr_d_next    = NOP_INSTR;
            w_skid_valid_next = 1'b0;
            case (r_state)
                ST_ISSUE: begin
                    if (w_accept) begin
                        w_state_next = ST_WAIT;
                        w_drop_next  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_resp_valid) begin
                        w_state_next = ST_ISSUE;
                        w_drop_next  = 1'b0;
                    end else begin
                        w_drop_next  = 1'b1;
                    end
                end
                default: w_state_next = ST_ISSUE;
            endcase
        end else begin
            if (r_valid_d && !StallD) begin
                w_valid_d_next = 1'b0;
                w_instr_d_next = NOP_INSTR;
            end
            case (r_state)
                ST_ISSUE: begin
                    if (w_accept) w_state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem.imem_resp_valid) begin
                        if (r_drop) begin
                            w_drop_next  = 1'b0;
                            w_state_next = ST_ISSUE;
                        end else if (w_d_free) begin
                            w_valid_d_next    = 1'b1;
                            w_instr_d_next    = imem.imem_rdata;
                            w_pc_d_next       = r_pcf;
                            w_pc_plus4_d_next = w_pcf_plus4;
                            w_pcf_next        = w_pcf_plus4;
                            w_state_next      = ST_ISSUE;
                        end else begin
                            w_skid_valid_next = 1'b1;
                            w_skid_instr_next = imem.imem_rdata;
                            w_skid_pc_next    = r_pcf;
                            w_pcf_next        = w_pcf_plus4;
                            w_state_next      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!StallD) begin
                        w_valid_d_next    = 1'b1;
                        w_instr_d_next    = r_skid_instr;
                        w_pc_d_next       = r_skid_pc;
                        w_pc_plus4_d_next = r_skid_pc + 32'd4;
                        w_skid_valid_next = 1'b0;
                        w_state_next      = ST_ISSUE;
                    end
                end
                default: w_state_next = ST_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ISSUE;
            r_pcf        <= RESET_PC;
            r_req_valid  <= 1'b0;
            r_drop       <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= 32'd0;
            r_valid_d    <= 1'b0;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
        end else begin
            r_state      <= w_state_next;
            r_pcf        <= w_pcf_next;
            // Request valid is registered, so it follows the state by one edge.
            r_req_valid  <= (w_state_next == ST_ISSUE);
            r_drop       <= w_drop_next;
            r_skid_valid <= w_skid_valid_next;
            r_skid_instr <= w_skid_instr_next;
            r_skid_pc    <= w_skid_pc_next;
            r_valid_d    <= w_valid_d_next;
            r_instr_d    <= w_instr_d_next;
            r_pc_d       <= w_pc_d_next;
            r_pc_plus4_d <= w_pc_plus4_d_next;
        end
    end

    assign imem.imem_req_valid = r_req_valid;
    assign imem.imem_addr      = r_pcf;
    assign InstrD              = r_instr_d;
    assign PCD                 = r_pc_d;
    assign PCPlus4D            = r_pc_plus4_d;
    assign ValidD              = r_valid_d;
    assign PCF                 = r_pcf;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-programmable memory model plus a scoreboard
// of expected IF/ID loads, with one task per scenario.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'd0;
    logic        StallD = 1'b0;
    logic [31:0] InstrD, PCD, PCPlus4D, PCF;
    logic        ValidD;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallD    (StallD),
        .imem      (bus),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .PCF       (PCF)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory model
    logic        mem_ready = 1'b0;
    int          mem_lat   = 1;
    logic        model_rv  = 1'b0;
    logic [31:0] model_rd  = 32'd0;
    logic        ovr_en    = 1'b0;
    logic [31:0] ovr_addr  = 32'd0;
    logic [31:0] ovr_data  = 32'd0;
    typedef struct { int due; logic [31:0] addr; } pend_t;
    pend_t pend_q[$];
    int    cyc = 0;
    logic        m_acc;
    logic [31:0] m_addr;
    int          m_lat;

    assign bus.imem_req_ready  = mem_ready;
    assign bus.imem_resp_valid = model_rv;
    assign bus.imem_rdata      = model_rd;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr_en && a == ovr_addr) return ovr_data;
        return a ^ 32'h5A5A_0013;
    endfunction

    initial forever begin
        pend_t p;
        @(negedge clk); #4;
        m_acc  = bus.imem_req_valid && mem_ready;
        m_addr = bus.imem_addr;
        m_lat  = mem_lat;
        @(posedge clk);
        cyc++;
        if (m_acc) begin
            p.due  = cyc + m_lat - 1;
            p.addr = m_addr;
            pend_q.push_back(p);
        end
        #1;
        model_rv = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            model_rv = 1'b1;
            model_rd = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
    end

    // Scoreboard of expected IF/ID loads
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    exp_t exp_q[$];
    logic mon_vd, mon_st;

    function automatic void push_exp(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endfunction

    initial forever begin
        exp_t e;
        @(negedge clk); #4;
        mon_vd = ValidD;
        mon_st = StallD;
        @(posedge clk); #2;
        if (ValidD === 1'b1 && (!mon_vd || !mon_st)) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_load PCD=%h InstrD=%h", PCD, InstrD);
            end else begin
                e = exp_q.pop_front();
                checks += 3;
                if (PCD !== e.pc) begin errors++; $display("FAIL load_pcd got=%h exp=%h", PCD, e.pc); end
                if (InstrD !== e.instr) begin errors++; $display("FAIL load_instr got=%h exp=%h", InstrD, e.instr); end
                if (PCPlus4D !== e.pc + 32'd4) begin errors++; $display("FAIL load_pcplus4 got=%h exp=%h", PCPlus4D, e.pc + 32'd4); end
                $display("load pc=%h instr=%h", PCD, InstrD);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy, input int lat);
        rst = 1'b1; PCSrcE = 1'b0; StallD = 1'b0; PCTargetE = 32'd0;
        mem_ready = rdy; mem_lat = lat; ovr_en = 1'b0;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained got=%0d pending exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b0;
        cycles(2);
        checks += 6;
        if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", bus.imem_req_valid); end
        if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_validd got=%b exp=0", ValidD); end
        if (InstrD !== NOP) begin errors++; $display("FAIL reset_instrd got=%h exp=%h", InstrD, NOP); end
        if (PCD !== 32'd0) begin errors++; $display("FAIL reset_pcd got=%h exp=0", PCD); end
        if (PCPlus4D !== 32'd0) begin errors++; $display("FAIL reset_pcplus4d got=%h exp=0", PCPlus4D); end
        if (PCF !== 32'd0) begin errors++; $display("FAIL reset_pcf got=%h exp=0", PCF); end
        rst = 1'b0;
        cycles(1);
        checks += 2;
        if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got=%b exp=1", bus.imem_req_valid); end
        if (bus.imem_addr !== 32'd0) begin errors++; $display("FAIL first_req_addr got=%h exp=0", bus.imem_addr); end
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        logic exp_v;
        do_reset(1'b1, 1);
        push_exp(32'd0, mem_word(32'd0));
        push_exp(32'd4, mem_word(32'd4));
        push_exp(32'd8, mem_word(32'd8));
        for (int k = 1; k <= 6; k++) begin
            cycles(1);
            exp_v = (k >= 3) && (k % 2 == 1);
            checks++;
            if (ValidD !== exp_v) begin errors++; $display("FAIL seq_validd_cycle%0d got=%b exp=%b", k, ValidD, exp_v); end
        end
        mem_ready = 1'b0;
        cycles(3);
        check_drained("seq");
        $display("test_sequential done");
    endtask

    task automatic test_stall_hold();
        do_reset(1'b1, 1);
        ovr_en = 1'b1; ovr_addr = 32'd4; ovr_data = 32'hDEAD_BEEF;
        push_exp(32'd0, mem_word(32'd0));
        push_exp(32'd4, 32'hDEAD_BEEF);
        cycles(3);
        StallD = 1'b1;
        cycles(2);
        checks += 3;
        if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL hold_req_valid got=%b exp=0", bus.imem_req_valid); end
        if (InstrD !== mem_word(32'd0)) begin errors++; $display("FAIL hold_instrd got=%h exp=%h", InstrD, mem_word(32'd0)); end
        if (PCF !== 32'd8) begin errors++; $display("FAIL hold_pcf got=%h exp=8", PCF); end
        cycles(1);
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL hold2_req_valid got=%b exp=0", bus.imem_req_valid); end
        StallD = 1'b0; mem_ready = 1'b0;
        cycles(1);
        checks += 3;
        if (InstrD !== 32'hDEAD_BEEF) begin errors++; $display("FAIL skid_instrd got=%h exp=deadbeef", InstrD); end
        if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL skid_req_valid got=%b exp=1", bus.imem_req_valid); end
        if (bus.imem_addr !== 32'd8) begin errors++; $display("FAIL skid_req_addr got=%h exp=8", bus.imem_addr); end
        cycles(3);
        check_drained("stall");
        $display("test_stall_hold done");
    endtask

    task automatic test_redirect_wait();
        do_reset(1'b1, 3);
        push_exp(32'h100, mem_word(32'h100));
        cycles(2);
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        cycles(1);
        PCSrcE = 1'b0;
        checks += 3;
        if (ValidD !== 1'b0) begin errors++; $display("FAIL rw_validd got=%b exp=0", ValidD); end
        if (PCF !== 32'h100) begin errors++; $display("FAIL rw_pcf got=%h exp=100", PCF); end
        if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_req_valid got=%b exp=0", bus.imem_req_valid); end
        cycles(2);
        checks += 2;
        if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rw_reissue_valid got=%b exp=1", bus.imem_req_valid); end
        if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rw_reissue_addr got=%h exp=100", bus.imem_addr); end
        cycles(1);
        mem_ready = 1'b0;
        cycles(5);
        check_drained("redirect_wait");
        $display("test_redirect_wait done");
    endtask

    task automatic test_redirect_resp();
        do_reset(1'b1, 1);
        push_exp(32'h200, mem_word(32'h200));
        cycles(2);
        PCSrcE = 1'b1; PCTargetE = 32'h203;
        cycles(1);
        PCSrcE = 1'b0;
        checks += 4;
        if (ValidD !== 1'b0) begin errors++; $display("FAIL rr_validd got=%b exp=0", ValidD); end
        if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rr_req_valid got=%b exp=1", bus.imem_req_valid); end
        if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL rr_req_addr got=%h exp=200", bus.imem_addr); end
        if (PCF !== 32'h200) begin errors++; $display("FAIL rr_pcf got=%h exp=200", PCF); end
        cycles(1);
        mem_ready = 1'b0;
        cycles(3);
        check_drained("redirect_resp");
        $display("test_redirect_resp done");
    endtask

    task automatic test_backpressure();
        do_reset(1'b0, 1);
        push_exp(32'd0, mem_word(32'd0));
        for (int k = 1; k <= 3; k++) begin
            cycles(1);
            checks += 2;
            if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_cycle%0d got=%b exp=1", k, bus.imem_req_valid); end
            if (bus.imem_addr !== 32'd0) begin errors++; $display("FAIL bp_addr_cycle%0d got=%h exp=0", k, bus.imem_addr); end
        end
        mem_ready = 1'b1;
        cycles(1);
        mem_ready = 1'b0;
        cycles(1);
        checks += 2;
        if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got=%b exp=1", bus.imem_req_valid); end
        if (bus.imem_addr !== 32'd4) begin errors++; $display("FAIL bp_next_addr got=%h exp=4", bus.imem_addr); end
        cycles(3);
        check_drained("backpressure");
        $display("test_backpressure done");
    endtask

    task automatic test_wrap_reset();
        do_reset(1'b0, 1);
        push_exp(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
        cycles(1);
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        cycles(1);
        PCSrcE = 1'b0; mem_ready = 1'b1;
        checks += 2;
        if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req_addr got=%h exp=fffffffc", bus.imem_addr); end
        if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL wrap_req_valid got=%b exp=1", bus.imem_req_valid); end
        cycles(2);
        checks += 3;
        if (PCPlus4D !== 32'd0) begin errors++; $display("FAIL wrap_pcplus4d got=%h exp=0", PCPlus4D); end
        if (PCF !== 32'd0) begin errors++; $display("FAIL wrap_pcf got=%h exp=0", PCF); end
        if (bus.imem_addr !== 32'd0) begin errors++; $display("FAIL wrap_next_addr got=%h exp=0", bus.imem_addr); end
        mem_lat = 3;
        cycles(1);
        rst = 1'b1; mem_ready = 1'b0;
        cycles(1);
        rst = 1'b0;
        checks += 3;
        if (ValidD !== 1'b0) begin errors++; $display("FAIL midrst_validd got=%b exp=0", ValidD); end
        if (InstrD !== NOP) begin errors++; $display("FAIL midrst_instrd got=%h exp=%h", InstrD, NOP); end
        if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_req_valid got=%b exp=0", bus.imem_req_valid); end
        cycles(2);
        checks += 3;
        if (ValidD !== 1'b0) begin errors++; $display("FAIL late_resp_validd got=%b exp=0", ValidD); end
        if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL late_resp_req_valid got=%b exp=1", bus.imem_req_valid); end
        if (bus.imem_addr !== 32'd0) begin errors++; $display("FAIL late_resp_addr got=%h exp=0", bus.imem_addr); end
        cycles(2);
        check_drained("wrap_reset");
        $display("test_wrap_reset done");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_resp();
        test_backpressure();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
